// File: rtl/skip_carry_adder.sv
// Carry-skip (carry-bypass) adder with a one-cycle registered output stage.
// Operands are split into fixed-size ripple blocks. A block whose bits all
// propagate forwards its incoming carry straight to the next block through a
// skip mux instead of waiting for the ripple chain.
module skip_carry_adder #(
  parameter int WIDTH      = 1,
  parameter int BLOCK_SIZE = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             valid_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             valid_o
);

  // Block size clamped into 1..WIDTH; the last block takes any remainder.
  localparam int BS   = (BLOCK_SIZE < 1)     ? 1     :
                        (BLOCK_SIZE > WIDTH) ? WIDTH : BLOCK_SIZE;
  localparam int NBLK = (WIDTH + BS - 1) / BS;

  // blk_c[k] is the carry entering block k; blk_c[NBLK] is the final carry-out.
  logic [NBLK:0]    blk_c;
  logic [WIDTH-1:0] sum_d;
  logic             c_into_msb;
  logic             cout_d;
  logic             ovf_d;

  assign blk_c[0] = cin_i;

  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    localparam int LO = k * BS;
    localparam int HI = ((k + 1) * BS > WIDTH) ? WIDTH - 1 : (k + 1) * BS - 1;
    localparam int N  = HI - LO + 1;

    logic [N-1:0] p;
    logic [N-1:0] g;
    logic [N:0]   c;

    assign p    = a_i[HI:LO] ^ b_i[HI:LO];
    assign g    = a_i[HI:LO] & b_i[HI:LO];
    assign c[0] = blk_c[k];

    // Ripple chain inside the block.
    for (genvar j = 0; j < N; j++) begin : g_bit
      assign c[j+1] = g[j] | (p[j] & c[j]);
    end

    assign sum_d[HI:LO] = p ^ c[N-1:0];

    // Skip mux: a fully propagating block passes its carry-in straight through.
    assign blk_c[k+1] = (&p) ? blk_c[k] : c[N];

    // The carry entering the MSB comes from the ripple chain of the last block.
    if (k == NBLK - 1) begin : g_msb
      assign c_into_msb = c[N-1];
    end
  end

  assign cout_d = blk_c[NBLK];
  // Signed overflow: carry into the MSB disagrees with carry out of the MSB.
  assign ovf_d  = c_into_msb ^ cout_d;

  // Output register: capture on valid_i, hold otherwise; reset wins over valid.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst_i) begin
      sum_o   <= '0;
      cout_o  <= 1'b0;
      ovf_o   <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= valid_i;
      // NOTE: the result registers have no else-branch on purpose; they hold
      // their value when valid_i is low, which is a clock-enable, not a latch.
      if (valid_i) begin
        sum_o  <= sum_d;
        cout_o <= cout_d;
        ovf_o  <= ovf_d;
      end
    end
  end

endmodule

// File: tb/tb_skip_carry_adder.sv
// Self-checking bench for skip_carry_adder. Three instances (WIDTH=1, a 16-bit
// with full 4-bit blocks, a 10-bit with a partial last block) share clock and
// reset. Expected values come from integer arithmetic on the operands.
module tb_skip_carry_adder;

  logic clk;
  logic rst;

  logic        a1, b1, cin1, v1;
  logic        s1, co1, ov1, vo1;

  logic [15:0] a16, b16, s16;
  logic        cin16, v16, co16, ov16, vo16;

  logic [9:0]  a10, b10, s10;
  logic        cin10, v10, co10, ov10, vo10;

  int checks;
  int errors;

  skip_carry_adder #(.WIDTH(1)) u_w1 (
    .clk_i(clk), .rst_i(rst), .a_i(a1), .b_i(b1), .cin_i(cin1), .valid_i(v1),
    .sum_o(s1), .cout_o(co1), .ovf_o(ov1), .valid_o(vo1)
  );

  skip_carry_adder #(.WIDTH(16), .BLOCK_SIZE(4)) u_w16 (
    .clk_i(clk), .rst_i(rst), .a_i(a16), .b_i(b16), .cin_i(cin16), .valid_i(v16),
    .sum_o(s16), .cout_o(co16), .ovf_o(ov16), .valid_o(vo16)
  );

  skip_carry_adder #(.WIDTH(10), .BLOCK_SIZE(4)) u_w10 (
    .clk_i(clk), .rst_i(rst), .a_i(a10), .b_i(b10), .cin_i(cin10), .valid_i(v10),
    .sum_o(s10), .cout_o(co10), .ovf_o(ov10), .valid_o(vo10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: unsigned sum for sum/carry, signed range check for overflow.
  function automatic void model(input int w, input logic [63:0] a,
                                input logic [63:0] b, input logic cin,
                                output logic [63:0] es, output logic ec,
                                output logic eo);
    logic [64:0] t;
    longint      lim, sa, sb, st;
    t   = {1'b0, a} + {1'b0, b} + {64'd0, cin};
    ec  = t[w];
    es  = t[63:0] & ((64'd1 << w) - 64'd1);
    lim = longint'(1) << (w - 1);
    sa  = a[w-1] ? longint'(a) - 2 * lim : longint'(a);
    sb  = b[w-1] ? longint'(b) - 2 * lim : longint'(b);
    st  = sa + sb + (cin ? 64'sd1 : 64'sd0);
    eo  = (st >= lim) || (st < -lim);
  endfunction

  // Advance one rising edge and settle a little past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    v1 = 1'b0; v16 = 1'b0; v10 = 1'b0;
  endtask

  // Drive the 16-bit instance, clock it, and compare with the model.
  task automatic run16(input string name, input logic [15:0] a,
                       input logic [15:0] b, input logic cin);
    logic [63:0] es;
    logic        ec, eo;
    a16 = a; b16 = b; cin16 = cin; v16 = 1'b1;
    model(16, 64'(a), 64'(b), cin, es, ec, eo);
    tick();
    checks++;
    if ({vo16, co16, ov16, s16} !== {1'b1, ec, eo, es[15:0]}) begin
      errors++;
      $display("FAIL %s: got valid=%b cout=%b ovf=%b sum=%h, expected valid=1 cout=%b ovf=%b sum=%h",
               name, vo16, co16, ov16, s16, ec, eo, es[15:0]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; v1 = 1'b1;
    a16 = 16'hFFFF; b16 = 16'h0001; cin16 = 1'b1; v16 = 1'b1;
    a10 = 10'h3FF; b10 = 10'h001; cin10 = 1'b1; v10 = 1'b1;
    tick();
    tick();
    checks++;
    if ({vo1, co1, ov1, s1} !== 4'b0) begin
      errors++;
      $display("FAIL reset_w1: got %b, expected 0000", {vo1, co1, ov1, s1});
    end
    checks++;
    if ({vo16, co16, ov16, s16} !== 19'b0) begin
      errors++;
      $display("FAIL reset_w16: got %h, expected 0", {vo16, co16, ov16, s16});
    end
    checks++;
    if ({vo10, co10, ov10, s10} !== 13'b0) begin
      errors++;
      $display("FAIL reset_w10: got %h, expected 0", {vo10, co10, ov10, s10});
    end
    rst = 1'b0;
    idle_all();
  endtask

  // Full-adder truth table on the 1-bit instance.
  task automatic test_w1_truth();
    logic [7:0]  sum_tbl;
    logic [7:0]  cout_tbl;
    logic [2:0]  v;
    logic [63:0] es;
    logic        ec, eo;
    sum_tbl  = 8'b1001_0110; // bit i is the sum for {a,b,cin}=i
    cout_tbl = 8'b1110_1000;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      a1 = v[2]; b1 = v[1]; cin1 = v[0]; v1 = 1'b1;
      model(1, 64'(v[2]), 64'(v[1]), v[0], es, ec, eo);
      tick();
      checks++;
      if ({vo1, co1, s1, ov1} !== {1'b1, cout_tbl[i], sum_tbl[i], eo}) begin
        errors++;
        $display("FAIL w1_truth[%0d]: got valid=%b cout=%b sum=%b ovf=%b, expected valid=1 cout=%b sum=%b ovf=%b",
                 i, vo1, co1, s1, ov1, cout_tbl[i], sum_tbl[i], eo);
      end
    end
    idle_all();
  endtask

  task automatic test_w16_boundaries();
    run16("w16_full_skip", 16'hFFFF, 16'h0000, 1'b1);
    checks++;
    if ({co16, ov16, s16} !== {1'b1, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL w16_full_skip_const: got cout=%b ovf=%b sum=%h, expected cout=1 ovf=0 sum=0000",
               co16, ov16, s16);
    end
    run16("w16_pos_ovf", 16'h7FFF, 16'h0001, 1'b0);
    checks++;
    if ({co16, ov16, s16} !== {1'b0, 1'b1, 16'h8000}) begin
      errors++;
      $display("FAIL w16_pos_ovf_const: got cout=%b ovf=%b sum=%h, expected cout=0 ovf=1 sum=8000",
               co16, ov16, s16);
    end
    run16("w16_neg_ovf", 16'h8000, 16'h8000, 1'b0);
    checks++;
    if ({co16, ov16, s16} !== {1'b1, 1'b1, 16'h0000}) begin
      errors++;
      $display("FAIL w16_neg_ovf_const: got cout=%b ovf=%b sum=%h, expected cout=1 ovf=1 sum=0000",
               co16, ov16, s16);
    end
    for (int i = 0; i < 200; i++) begin
      run16("w16_random", 16'($urandom), 16'($urandom), 1'($urandom));
    end
    idle_all();
  endtask

  task automatic test_w10_random();
    logic [63:0] es;
    logic        ec, eo;
    a10 = 10'h3FF; b10 = 10'h001; cin10 = 1'b0; v10 = 1'b1;
    tick();
    checks++;
    if ({vo10, co10, s10} !== {1'b1, 1'b1, 10'h000}) begin
      errors++;
      $display("FAIL w10_partial_block: got valid=%b cout=%b sum=%h, expected valid=1 cout=1 sum=000",
               vo10, co10, s10);
    end
    for (int i = 0; i < 10000; i++) begin
      a10 = 10'($urandom); b10 = 10'($urandom); cin10 = 1'($urandom); v10 = 1'b1;
      model(10, 64'(a10), 64'(b10), cin10, es, ec, eo);
      tick();
      checks++;
      if ({vo10, co10, ov10, s10} !== {1'b1, ec, eo, es[9:0]}) begin
        errors++;
        $display("FAIL w10_random[%0d]: a=%h b=%h cin=%b got cout=%b ovf=%b sum=%h valid=%b, expected cout=%b ovf=%b sum=%h",
                 i, a10, b10, cin10, co10, ov10, s10, vo10, ec, eo, es[9:0]);
      end
    end
    idle_all();
  endtask

  task automatic test_control();
    logic [18:0] held;
    run16("ctrl_load", 16'h1234, 16'h1111, 1'b0);
    held = {co16, ov16, s16};
    checks++;
    if (held !== {1'b0, 1'b0, 16'h2345}) begin
      errors++;
      $display("FAIL ctrl_load_const: got %h, expected %h", held, {3'b000, 16'h2345});
    end
    v16 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
      tick();
      checks++;
      if ({vo16, co16, ov16, s16} !== {1'b0, 3'b000, 16'h2345}) begin
        errors++;
        $display("FAIL ctrl_hold[%0d]: got valid=%b cout=%b ovf=%b sum=%h, expected valid=0 cout=0 ovf=0 sum=2345",
                 i, vo16, co16, ov16, s16);
      end
    end
    rst = 1'b1; v16 = 1'b1; a16 = 16'h7FFF; b16 = 16'h7FFF; cin16 = 1'b1;
    tick();
    checks++;
    if ({vo16, co16, ov16, s16} !== 19'b0) begin
      errors++;
      $display("FAIL ctrl_reset_priority: got %h, expected 0", {vo16, co16, ov16, s16});
    end
    rst = 1'b0;
    run16("ctrl_after_reset", 16'h00F0, 16'h0F0F, 1'b1);
    idle_all();
  endtask

  task automatic test_back_to_back();
    logic [15:0] base;
    base = 16'($urandom);
    for (int i = 0; i < 4; i++) begin
      run16("b2b", base + 16'(i * 16'h1357), 16'(i * 16'h2468) ^ 16'hA5A5, 1'(i));
    end
    v16 = 1'b0;
    tick();
    checks++;
    if (vo16 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drop: got valid=%b, expected 0", vo16);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    a16 = '0; b16 = '0; cin16 = 1'b0;
    a10 = '0; b10 = '0; cin10 = 1'b0;
    idle_all();

    test_reset();
    test_w1_truth();
    test_w16_boundaries();
    test_w10_random();
    test_control();
    test_back_to_back();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/skip_carry_adder.md
Name: skip_carry_adder

Overview:
- Parameterizable carry-skip (carry-bypass) adder with registered outputs, used as the add stage of the team's signed-adder datapath.
- Computes a_i + b_i + cin_i using fixed-size ripple blocks whose carry is bypassed when the whole block propagates.
- Produces sum, carry-out and signed overflow one clock after the inputs are sampled.
- Default configuration is a single-bit full adder; wider instances are built by raising WIDTH.

Parameters:
- WIDTH, 1, operand and sum width in bits; legal range 1..64.
- BLOCK_SIZE, 4, bits per ripple/skip block; legal range 1..WIDTH (clamped to WIDTH if larger). The last block holds the remainder when WIDTH is not a multiple of BLOCK_SIZE.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous active-high reset.
- a_i  input  WIDTH  operand A, two's complement.
- b_i  input  WIDTH  operand B, two's complement.
- cin_i  input  1  carry-in.
- valid_i  input  1  input qualifier; operands are captured only when high.
- sum_o  output  WIDTH  registered sum, (a_i + b_i + cin_i) mod 2^WIDTH.
- cout_o  output  1  registered unsigned carry-out of the MSB.
- ovf_o  output  1  registered signed overflow.
- valid_o  output  1  high for the cycle in which sum_o/cout_o/ovf_o hold a fresh result.

Behaviour:
- Reset: on a rising edge with rst_i=1, sum_o=0, cout_o=0, ovf_o=0, valid_o=0. rst_i has priority over valid_i in the same cycle.
- Latency is exactly 1 cycle. With valid_i=1 at edge N, results appear after edge N and valid_o=1 until the next edge.
- With valid_i=0 at an edge, valid_o goes to 0 and sum_o/cout_o/ovf_o hold their previous values.
- No backpressure. A new operand can be accepted every cycle, giving full throughput.
- Block structure (combinational): block k covers bits [k*BLOCK_SIZE, min((k+1)*BLOCK_SIZE, WIDTH)-1].
  - Per bit: p = a^b, g = a&b.
  - Ripple within the block: c[i+1] = g | (p & c[i]); s = p ^ c[i].
  - Block propagate P_k = AND of p over the block.
  - Block carry-out = P_k ? block_cin : ripple carry-out.
  - Block 0 carry-in is cin_i.
- The skip mux is an explicit structure and must not be collapsed into a plain "+".
- Results are bit-exact with the WIDTH+1-bit sum a_i + b_i + cin_i for every input.
- cout_o = bit WIDTH of that sum.
- ovf_o = carry into MSB XOR carry out of MSB, which equals (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]).
- With WIDTH=1 the block is a registered full adder. ovf_o is still defined by the same rule.
- Reset asserted mid-stream clears the outputs on that edge. The first valid operand after reset deasserts produces its result one cycle later.
- No X propagation from reset state; outputs are known from the first reset edge.

Test Plan:
- WIDTH=1: reset, then apply all 8 combinations of {a_i,b_i,cin_i}=0..7 with valid_i=1, one per cycle.
  - Required sum_o/cout_o sequence, one cycle later: 0/0, 1/0, 1/0, 0/1, 1/0, 0/1, 0/1, 1/1.
- WIDTH=16, BLOCK_SIZE=4: a=0xFFFF, b=0x0000, cin=1 (full propagate, all blocks skip) -> sum_o=0x0000, cout_o=1, ovf_o=0.
- WIDTH=16: a=0x7FFF, b=0x0001, cin=0 -> sum_o=0x8000, cout_o=0, ovf_o=1. Also a=0x8000, b=0x8000 -> sum_o=0x0000, cout_o=1, ovf_o=1.
- WIDTH=10, BLOCK_SIZE=4 (partial last block): a=0x3FF, b=0x001, cin=0 -> sum_o=0x000, cout_o=1. Then 10k random vectors compared against a+b+cin.
- Control: hold valid_i=0 for 3 cycles after a result -> valid_o=0 and sum_o unchanged.
  - Then assert rst_i together with valid_i=1 -> all outputs 0 on that edge.
- Back-to-back: valid_i=1 on 4 consecutive cycles with distinct operands -> 4 consecutive valid_o pulses, each result matching its operands from one cycle earlier.
